// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Decimal digits needed to show the largest unsigned value of the given width.
  function automatic int bcd_digits_for(input int width);
    longint unsigned max_v;
    int              d;
    max_v = (64'd1 << width) - 64'd1;
    d     = 32'sd1;
    for (int i = 0; i < 20; i++) begin
      if (max_v >= 64'd10) begin
        max_v = max_v / 64'd10;
        d     = d + 32'sd1;
      end else begin
        max_v = max_v;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// One BCD digit correction step: values of 5 or more get 3 added before the shift.
module bcd_dabble_cell (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3 correction, 4-bit wrap with no carry out of the digit.
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a leading-zero blank mask and an overflow flag for too-large values.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1'b1;

  state_t                state_r, next_state_s;
  logic [BIN_W-1:0]      shreg_r, shreg_next_s;
  logic [4*DIGITS-1:0]   work_r, adj_s, work_next_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  ovf_work_r, ovf_bit_s;
  logic                  accept_s, finish_s, zero_above_s;
  logic                  done_r, overflow_r;
  logic [4*DIGITS-1:0]   bcd_r;
  logic [DIGITS-1:0]     blank_r, blank_next_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    bcd_dabble_cell u_cell (
      .din  (work_r[4*g +: 4]),
      .dout (adj_s[4*g +: 4])
    );
  end

  // The shift register MSB feeds the units digit; the top digit MSB falls out as overflow.
  assign ovf_bit_s    = adj_s[4*DIGITS-1];
  assign work_next_s  = {adj_s[4*DIGITS-2:0], shreg_r[BIN_W-1]};
  assign shreg_next_s = shreg_r << 1'b1;

  // Leading-zero mask of the post-shift digits; units digit is never blanked.
  always_comb begin
    blank_next_s = {DIGITS{1'b0}};
    zero_above_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above_s    = zero_above_s & (work_next_s[4*k +: 4] == 4'd0);
      blank_next_s[k] = zero_above_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_SHIFT;
          accept_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_IDLE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Work datapath and result registers; results load only on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r    <= {BIN_W{1'b0}};
      work_r     <= {(4*DIGITS){1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ovf_work_r <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= {(4*DIGITS){1'b0}};
      blank_r    <= BLANK_RST;
      overflow_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        shreg_r    <= binary;
        work_r     <= {(4*DIGITS){1'b0}};
        cnt_r      <= CNT_LOAD;
        ovf_work_r <= 1'b0;
      end else if (state_r == ST_SHIFT) begin
        shreg_r    <= shreg_next_s;
        work_r     <= work_next_s;
        cnt_r      <= cnt_r - CNT_W'(1);
        ovf_work_r <= ovf_work_r | ovf_bit_s;
        if (finish_s) begin
          bcd_r      <= work_next_s;
          blank_r    <= blank_next_s;
          overflow_r <= ovf_work_r | ovf_bit_s;
        end
      end
    end
  end

  assign busy     = (state_r == ST_SHIFT);
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign blank    = blank_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq in three parameterisations.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a = 1'b0, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a = 8'd0;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;

  logic        start_b = 1'b0, busy_b, done_b, ovf_b;
  logic [15:0] bin_b = 16'd0;
  logic [19:0] bcd_b;
  logic [4:0]  blank_b;

  logic        start_c = 1'b0, busy_c, done_c, ovf_c;
  logic [7:0]  bin_c = 8'd0;
  logic [7:0]  bcd_c;
  logic [1:0]  blank_c;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a), .busy(busy_a),
    .done(done_a), .bcd(bcd_a), .blank(blank_a), .overflow(ovf_a));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b), .busy(busy_b),
    .done(done_b), .bcd(bcd_b), .blank(blank_b), .overflow(ovf_b));

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c), .busy(busy_c),
    .done(done_c), .bcd(bcd_c), .blank(blank_c), .overflow(ovf_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Counts rising edges from now until done is seen (bounded).
  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (sel_done(sel) !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic conv(input int sel, input logic [15:0] v, output int n);
    @(negedge clk);
    case (sel)
      0:       begin start_a = 1'b1; bin_a = v[7:0]; end
      1:       begin start_b = 1'b1; bin_b = v;      end
      default: begin start_c = 1'b1; bin_c = v[7:0]; end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    wait_done(sel, n);
  endtask

  initial begin
    #12;
    check("rst_busy",  busy_a,  1'b0);
    check("rst_done",  done_a,  1'b0);
    check("rst_bcd",   bcd_a,   12'h000);
    check("rst_blank", blank_a, 3'b110);
    check("rst_ovf",   ovf_a,   1'b0);
    check("rst_blank_b", blank_b, 5'b11110);
    check("rst_blank_c", blank_c, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;

    conv(0, 16'd255, lat);
    check("lat_255",   lat,     8);
    check("bcd_255",   bcd_a,   12'h255);
    check("blank_255", blank_a, 3'b000);
    check("ovf_255",   ovf_a,   1'b0);
    @(posedge clk); #1;
    check("done_1cyc", done_a,  1'b0);

    conv(0, 16'd0, lat);
    check("bcd_0",   bcd_a,   12'h000);
    check("blank_0", blank_a, 3'b110);
    conv(0, 16'd7, lat);
    check("bcd_7",   bcd_a,   12'h007);
    check("blank_7", blank_a, 3'b110);
    conv(0, 16'd42, lat);
    check("bcd_42",   bcd_a,   12'h042);
    check("blank_42", blank_a, 3'b100);

    conv(1, 16'd65535, lat);
    check("lat_65535",   lat,     16);
    check("bcd_65535",   bcd_b,   20'h65535);
    check("blank_65535", blank_b, 5'b00000);
    check("ovf_65535",   ovf_b,   1'b0);
    conv(1, 16'd10000, lat);
    check("bcd_10000",   bcd_b,   20'h10000);
    conv(1, 16'd7, lat);
    check("blank_b7",    blank_b, 5'b11110);

    conv(2, 16'd100, lat);
    check("ovf_100",   ovf_c,   1'b1);
    check("bcd_100",   bcd_c,   8'h00);
    check("blank_100", blank_c, 2'b10);
    conv(2, 16'd99, lat);
    check("ovf_99",    ovf_c,   1'b0);
    check("bcd_99",    bcd_c,   8'h99);
    check("blank_99",  blank_c, 2'b00);

    // Start 200, then a second start while busy must be ignored.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 8'd200;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (done_a !== 1'b1 && lat < 60) begin
      if (lat == 3) begin
        start_a = 1'b1;
        bin_a   = 8'd5;
      end else begin
        start_a = 1'b0;
      end
      if (lat == 4) check("hold_busy", bcd_a, 12'h042);
      if (lat == 4) check("busy_mid",  busy_a, 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    start_a = 1'b0;
    check("lat_200", lat,   8);
    check("bcd_200", bcd_a, 12'h200);

    // Start in the done cycle is accepted.
    start_a = 1'b1;
    bin_a   = 8'd5;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("done_drop", done_a, 1'b0);
    check("busy_acc",  busy_a, 1'b1);
    wait_done(0, lat);
    check("lat_5",   lat,   8);
    check("bcd_5",   bcd_a, 12'h005);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 8'd255;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_bcd",  bcd_a,  12'h000);
    check("abort_blank", blank_a, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) pulses++;
    end
    check("abort_nodone", pulses, 0);
    check("abort_hold",   bcd_a,  12'h000);

    conv(0, 16'd128, lat);
    check("lat_128",   lat,     8);
    check("bcd_128",   bcd_a,   12'h128);
    check("blank_128", blank_a, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
